// File: rtl/AXI_define.sv
// Shared AXI4 widths, encodings and the fixed single-beat attributes used by the
// data-memory bridge, plus its FSM state type.
package AXI_define;

  localparam int XLEN          = 32;
  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // Every data-memory access is one 4-byte INCR beat.
  localparam logic [AXI_LEN_BITS-1:0]  DMEM_AXI_LEN   = '0;
  localparam logic [AXI_SIZE_BITS-1:0] DMEM_AXI_SIZE  = 3'd2;
  localparam logic [1:0]               DMEM_AXI_BURST = AXI_BURST_INCR;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_DONE
  } dmem_axi_state_e;

  function automatic logic resp_bad(input logic [1:0] resp,
                                    input logic [AXI_ID_BITS-1:0] id,
                                    input logic [AXI_ID_BITS-1:0] exp_id);
    return (resp != AXI_RESP_OKAY) || (id != exp_id);
  endfunction

endpackage

// File: rtl/axi_wr_issue.sv
// AW/W dual-valid tracker: raises both VALIDs on start, drops each after its own
// handshake and pulses both_done in the cycle the later (or joint) handshake lands.
module axi_wr_issue (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic start,
  input  logic AWREADY,
  input  logic WREADY,
  output logic AWVALID,
  output logic WVALID,
  output logic both_done
);

  logic busy;
  logic aw_done;
  logic w_done;
  logic aw_ok;
  logic w_ok;

  assign aw_ok     = aw_done | (AWVALID & AWREADY);
  assign w_ok      = w_done  | (WVALID & WREADY);
  assign both_done = busy & aw_ok & w_ok;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      busy    <= 1'b0;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      AWVALID <= 1'b1;
      WVALID  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (both_done) begin
      busy    <= 1'b0;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (AWVALID && AWREADY) begin
        AWVALID <= 1'b0;
        aw_done <= 1'b1;
      end
      if (WVALID && WREADY) begin
        WVALID <= 1'b0;
        w_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_axi_master.sv
// MEM-stage data port to AXI master bridge: one single-beat AXI transaction per
// load/store, stalling the core until completion. Optional DMEM_AXI_RESP_CHECK_EN.
module dmem_axi_master
  import AXI_define::*;
#(
  parameter logic [AXI_ID_BITS-1:0] M_ID = 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [XLEN-1:0]          dmem_addr,
  input  logic                     dmem_wen,
  input  logic [AXI_STRB_BITS-1:0] dmem_wstrb,
  input  logic [XLEN-1:0]          dmem_wdata,
  input  logic                     dmem_ren,
  output logic [XLEN-1:0]          dmem_rdata,
  output logic                     stall_o,
  output logic [AXI_ID_BITS-1:0]   ARID,
  output logic [AXI_ADDR_BITS-1:0] ARADDR,
  output logic [AXI_LEN_BITS-1:0]  ARLEN,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE,
  output logic [1:0]               ARBURST,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  input  logic [AXI_ID_BITS-1:0]   RID,
  input  logic [AXI_DATA_BITS-1:0] RDATA,
  input  logic [1:0]               RRESP,
  input  logic                     RLAST,
  input  logic                     RVALID,
  output logic                     RREADY,
  output logic [AXI_ID_BITS-1:0]   AWID,
  output logic [AXI_ADDR_BITS-1:0] AWADDR,
  output logic [AXI_LEN_BITS-1:0]  AWLEN,
  output logic [AXI_SIZE_BITS-1:0] AWSIZE,
  output logic [1:0]               AWBURST,
  output logic                     AWVALID,
  input  logic                     AWREADY,
  output logic [AXI_DATA_BITS-1:0] WDATA,
  output logic [AXI_STRB_BITS-1:0] WSTRB,
  output logic                     WLAST,
  output logic                     WVALID,
  input  logic                     WREADY,
  input  logic [AXI_ID_BITS-1:0]   BID,
  input  logic [1:0]               BRESP,
  input  logic                     BVALID,
  output logic                     BREADY
`ifdef DMEM_AXI_RESP_CHECK_EN
  ,
  output logic                     resp_err_o
`endif
);

  dmem_axi_state_e          state;
  logic [XLEN-1:0]          addr_q;
  logic [XLEN-1:0]          wdata_q;
  logic [AXI_STRB_BITS-1:0] wstrb_q;
  logic                     wr_start;
  logic                     wr_both_done;
  logic                     unused_resp;

  assign ARID    = M_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = DMEM_AXI_LEN;
  assign ARSIZE  = DMEM_AXI_SIZE;
  assign ARBURST = DMEM_AXI_BURST;

  assign AWID    = M_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = DMEM_AXI_LEN;
  assign AWSIZE  = DMEM_AXI_SIZE;
  assign AWBURST = DMEM_AXI_BURST;

  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;

  // Combinational so the core stalls in the very cycle it presents the request.
  assign stall_o = ((state == ST_IDLE) & (dmem_ren | dmem_wen)) |
                   ((state != ST_IDLE) & (state != ST_DONE));

  assign wr_start = (state == ST_IDLE) & dmem_wen;

  axi_wr_issue u_wr_issue (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .start     (wr_start),
    .AWREADY   (AWREADY),
    .WREADY    (WREADY),
    .AWVALID   (AWVALID),
    .WVALID    (WVALID),
    .both_done (wr_both_done)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= ST_IDLE;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      BREADY     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      dmem_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A store wins when both requests are (illegally) raised together.
          if (dmem_wen) begin
            addr_q  <= dmem_addr;
            wdata_q <= dmem_wdata;
            wstrb_q <= dmem_wstrb;
            state   <= ST_WR_REQ;
          end else if (dmem_ren) begin
            addr_q  <= dmem_addr;
            wdata_q <= dmem_wdata;
            wstrb_q <= dmem_wstrb;
            ARVALID <= 1'b1;
            state   <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (RVALID) begin
            RREADY     <= 1'b0;
            dmem_rdata <= RDATA;
            state      <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          if (wr_both_done) begin
            BREADY <= 1'b1;
            state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (BVALID) begin
            BREADY <= 1'b0;
            state  <= ST_DONE;
          end
        end
        // One unstalled cycle lets the pipeline retire the still-present request.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_AXI_RESP_CHECK_EN
  assign unused_resp = RLAST;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      resp_err_o <= 1'b0;
    end else if ((RVALID & RREADY & resp_bad(RRESP, RID, M_ID)) |
                 (BVALID & BREADY & resp_bad(BRESP, BID, M_ID))) begin
      resp_err_o <= 1'b1;
    end
  end
`else
  assign unused_resp = ^{RID, RRESP, RLAST, BID, BRESP};
`endif

endmodule
